// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the fetch PC and issues requests to a variable-latency imem.
// Latency: a response accepted in cycle n shows up on PC/Instruction/if_valid in cycle n+1.
// Backpressure: freeze parks one fetched word and holds the outputs; redirects drain the outstanding request.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   freeze                hazard stall, holds the IF/ID outputs
//   Br_taken/Branch_Address  single-cycle redirect pulse and its target
//   imem_req/imem_addr    request to instruction memory (address stable while outstanding)
//   imem_ready/imem_rdata response handshake, data valid in the ready cycle
//   PC/Instruction/if_valid  registered IF/ID payload (PC is fetched address + 4)
module fetch_controller #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        Br_taken,
   input  logic [31:0] Branch_Address,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC,
   output logic [31:0] Instruction,
   output logic        if_valid
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_PARK  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] addr_reg, addr_nxt;
   logic [31:0] tgt_reg, tgt_nxt;
   logic [31:0] park_instr, park_instr_nxt;
   logic [31:0] park_pc, park_pc_nxt;
   logic [31:0] pc_nxt;
   logic [31:0] instr_nxt;
   logic        valid_nxt;
   logic [31:0] addr_inc;

   // Wraps naturally at 2^32.
   assign addr_inc  = addr_reg + 32'd4;

   // Request is suppressed while reset is held so nothing is issued in the reset cycle.
   assign imem_req  = !rst && (state != S_PARK);
   assign imem_addr = addr_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_REQ;
         addr_reg    <= RESET_PC;
         tgt_reg     <= 32'd0;
         park_instr  <= 32'd0;
         park_pc     <= 32'd0;
         PC          <= 32'd0;
         Instruction <= 32'd0;
         if_valid    <= 1'b0;
      end else begin
         state       <= state_nxt;
         addr_reg    <= addr_nxt;
         tgt_reg     <= tgt_nxt;
         park_instr  <= park_instr_nxt;
         park_pc     <= park_pc_nxt;
         PC          <= pc_nxt;
         Instruction <= instr_nxt;
         if_valid    <= valid_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      addr_nxt       = addr_reg;
      tgt_nxt        = tgt_reg;
      park_instr_nxt = park_instr;
      park_pc_nxt    = park_pc;
      pc_nxt         = PC;
      instr_nxt      = Instruction;
      valid_nxt      = if_valid;

      case (state)
         S_REQ: begin
            if (imem_ready) begin
               if (Br_taken) begin
                  // Response is for the wrong path; refetch at the target.
                  addr_nxt  = Branch_Address;
                  valid_nxt = 1'b0;
               end else if (freeze) begin
                  park_instr_nxt = imem_rdata;
                  park_pc_nxt    = addr_inc;
                  addr_nxt       = addr_inc;
                  state_nxt      = S_PARK;
               end else begin
                  instr_nxt = imem_rdata;
                  pc_nxt    = addr_inc;
                  valid_nxt = 1'b1;
                  addr_nxt  = addr_inc;
               end
            end else if (Br_taken) begin
               // The request can't be withdrawn, so remember the target and drain.
               tgt_nxt   = Branch_Address;
               valid_nxt = 1'b0;
               state_nxt = S_DRAIN;
            end
         end

         S_PARK: begin
            if (Br_taken) begin
               park_instr_nxt = 32'd0;
               park_pc_nxt    = 32'd0;
               addr_nxt       = Branch_Address;
               valid_nxt      = 1'b0;
               state_nxt      = S_REQ;
            end else if (!freeze) begin
               instr_nxt = park_instr;
               pc_nxt    = park_pc;
               valid_nxt = 1'b1;
               state_nxt = S_REQ;
            end
         end

         S_DRAIN: begin
            if (Br_taken) begin
               // Latest redirect wins, even when it lands on the draining response.
               tgt_nxt = Branch_Address;
               if (imem_ready) begin
                  addr_nxt  = Branch_Address;
                  state_nxt = S_REQ;
               end
            end else if (imem_ready) begin
               addr_nxt  = tgt_reg;
               state_nxt = S_REQ;
            end
         end

         default: state_nxt = S_REQ;
      endcase
   end

endmodule
